// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the Wishbone single-transfer initiator.
//   - wb_state_e : initiator FSM encoding (IDLE / BUS / RESP)
//   - RSP_OK/RSP_ERR : values carried on rsp_err
//   - WB_AW_DEF/WB_DW_DEF/WB_TIMEOUT_DEF : default widths and watchdog limit
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    localparam int unsigned WB_AW_DEF      = 32;
    localparam int unsigned WB_DW_DEF      = 32;
    localparam int unsigned WB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: bus-cycle watchdog counter.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear the count (held while the initiator is idle)
//   en_i         : count this cycle (initiator is in BUS)
//   expired_o    : this is the TIMEOUT-th enabled cycle since the last clear
// Expiry is combinational so the owner terminates on the same edge that ends
// the TIMEOUT-th cycle, giving a strobe exactly TIMEOUT cycles long.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of BUS cycles already completed.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-transfer bus master.
// Accepts one command on a valid/ready port, runs one read or write cycle,
// and returns read data / error status on a valid/ready response port.
// Optional feature macro: WB_INITIATOR_TIMEOUT_EN (bus watchdog; when
// undefined the BUS state waits indefinitely for ack/err).
// Ports:
//   wb_clk_i, wb_reset_i        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake (ready only in IDLE)
//   cmd_we/adr/dat/sel          : command fields, sampled at accept only
//   rsp_valid/rsp_ready         : response handshake
//   rsp_dat, rsp_err            : read data (0 for writes/errors), error flag
//   wb_adr_o..wb_stb_o          : registered Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i: Wishbone responder inputs
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned AW      = WB_AW_DEF,
    parameter int unsigned DW      = WB_DW_DEF,
    parameter int unsigned TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);

    wb_state_e       state_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;
    logic [DW/8-1:0] sel_q;
    logic            we_q;
    logic            cyc_q;
    logic            stb_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_dat_q;
    logic            rsp_err_q;
    logic            timeout;

`ifdef WB_INITIATOR_TIMEOUT_EN
    // Count held at zero in IDLE so it starts fresh on every BUS entry.
    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_reset_i),
        .clr_i     (state_q == ST_IDLE),
        .en_i      (state_q == ST_BUS),
        .expired_o (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign timeout = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE);

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= RSP_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        adr_q   <= cmd_adr;
                        dat_q   <= cmd_dat;
                        sel_q   <= cmd_sel;
                        we_q    <= cmd_we;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_ack_i || wb_err_i || timeout) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                        // err (or watchdog) dominates a simultaneous ack
                        if (wb_err_i || timeout) begin
                            rsp_dat_q <= '0;
                            rsp_err_q <= RSP_ERR;
                        end else begin
                            rsp_dat_q <= we_q ? '0 : wb_dat_i;
                            rsp_err_q <= RSP_OK;
                        end
                    end
                end
                ST_RESP: begin
                    // Leaving through RESP keeps stb low for at least one
                    // cycle, so edge-detecting responders see a new strobe.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int checks;
    int failures;

    wb_initiator #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_reset_i (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_err    (rsp_err),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: LED register at adr 0 (byte-selectable), buttons at adr 3.
    // Registered ack one cycle after it sees stb.
    logic [31:0] led_q;
    logic [1:0]  buttons;
    bit          err_mode;
    bit          silent;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wb_dat_i <= 32'h0;
            led_q    <= 32'h0;
        end else begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wb_dat_i <= 32'h0;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !silent) begin
                wb_ack_i <= 1'b1;
                if (err_mode) begin
                    wb_err_i <= 1'b1;
                    wb_dat_i <= 32'h1234_5678;
                end else if (wb_we_o) begin
                    wb_dat_i <= 32'hCAFE_F00D;
                    if (wb_adr_o == 32'h0)
                        for (int b = 0; b < 4; b++)
                            if (wb_sel_o[b]) led_q[8*b +: 8] <= wb_dat_o[8*b +: 8];
                end else begin
                    wb_dat_i <= (wb_adr_o == 32'h0) ? led_q :
                                (wb_adr_o == 32'h3) ? {30'h0, buttons} : 32'h0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer; optionally hold rsp_ready low for `hold` cycles
    // while offering another command that must not be taken.
    task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int hold,
                            output logic [31:0] rdat, output logic rerr, output int stbc);
        int viol;
        @(negedge clk);
        chk("acc_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("wb_adr", wb_adr_o, adr);
        chk("wb_dat", wb_dat_o, dat);
        chk("wb_sel", {28'h0, wb_sel_o}, {28'h0, sel});
        chk("wb_we", {31'h0, wb_we_o}, {31'h0, we});
        chk("wb_cyc", {31'h0, wb_cyc_o}, 32'h1);
        stbc = wb_stb_o ? 1 : 0;
        cmd_adr = 32'hFFFF_FFF0; cmd_dat = ~dat; cmd_sel = ~sel; cmd_we = ~we;
        @(negedge clk);
        chk("wb_hold", wb_dat_o ^ wb_adr_o, dat ^ adr);
        for (int n = 0; n < 50 && !rsp_valid; n++) begin
            if (wb_stb_o) stbc++;
            @(negedge clk);
        end
        chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rdat = rsp_dat;
        rerr = rsp_err;
        viol = 0;
        for (int n = 0; n < hold; n++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            if (!rsp_valid || rsp_dat !== rdat || rsp_err !== rerr || cmd_ready || wb_stb_o || wb_cyc_o)
                viol++;
        end
        cmd_valid = 1'b0;
        if (hold > 0) chk("hold_stable", viol, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("back_idle", {31'h0, cmd_ready}, 32'h1);
    endtask

    logic [31:0] rd;
    logic        re;
    int          sc;
    int          first, second, nrsp, bad, i1, j0, i2;
    logic [15:0] sv;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
        cmd_sel = 4'h0; rsp_ready = 1'b0; buttons = 2'b10; err_mode = 0; silent = 0;

        // Reset state
        #12;
        chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("rst_we", {31'h0, wb_we_o}, 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", {28'h0, wb_sel_o}, 32'h0);
        chk("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        chk("rst_rdat", rsp_dat, 32'h0);
        chk("rst_ready", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Write 0xA5 to LED with only byte 0 selected
        run_xfer(1'b1, 32'h0, 32'h5A5A_5AA5, 4'b0001, 0, rd, re, sc);
        chk("wr_stb_cycles", sc, 2);
        chk("wr_err", {31'h0, re}, 32'h0);
        chk("wr_rdat_zero", rd, 32'h0);

        // Readback adr 0
        run_xfer(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, re, sc);
        chk("rd_led", rd, 32'h0000_00A5);
        chk("rd_led_err", {31'h0, re}, 32'h0);

        // Read buttons
        run_xfer(1'b0, 32'h3, 32'h0, 4'hF, 0, rd, re, sc);
        chk("rd_btn", rd, 32'h0000_0002);
        chk("rd_btn_err", {31'h0, re}, 32'h0);

        // Back-to-back reads with rsp_ready held high
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_we = 1'b0; cmd_adr = 32'h3; cmd_sel = 4'hF; cmd_valid = 1'b1;
        first = -1; second = -1; nrsp = 0; bad = 0; sv = '0;
        for (int n = 0; n < 16; n++) begin
            if (cmd_valid && cmd_ready) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            if (second >= 0 && n > second) cmd_valid = 1'b0;
            sv[n] = wb_stb_o;
            if (rsp_valid) begin
                nrsp++;
                if (rsp_dat !== 32'h2 || rsp_err !== 1'b0) bad++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        i1 = -1; j0 = -1; i2 = -1;
        for (int n = 0; n < 16; n++) begin
            if (i1 < 0 && sv[n]) i1 = n;
            else if (i1 >= 0 && j0 < 0 && !sv[n]) j0 = n;
            else if (j0 >= 0 && i2 < 0 && sv[n]) i2 = n;
        end
        chk("b2b_period", second - first, 4);
        chk("b2b_gap_ge1", {31'h0, (i2 - j0) >= 1 && j0 >= 0}, 32'h1);
        chk("b2b_rsp_cnt", nrsp, 2);
        chk("b2b_rsp_dat", bad, 0);

        // ack and err together: err wins
        err_mode = 1;
        run_xfer(1'b0, 32'h3, 32'h0, 4'hF, 0, rd, re, sc);
        err_mode = 0;
        chk("err_flag", {31'h0, re}, 32'h1);
        chk("err_rdat", rd, 32'h0);

        // Backpressure: rsp_ready low 10 cycles
        run_xfer(1'b0, 32'h0, 32'h0, 4'hF, 10, rd, re, sc);
        chk("bp_rdat", rd, 32'h0000_00A5);

        // Async reset mid-BUS
        silent = 1;
        @(negedge clk);
        cmd_we = 1'b0; cmd_adr = 32'h0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_stb_hi", {31'h0, wb_stb_o}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("mid_rst_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("mid_rst_rsp", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("mid_no_rsp", {31'h0, rsp_valid}, 32'h0);

        // Silent responder: watchdog or indefinite wait
        @(negedge clk);
        cmd_adr = 32'h3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        sc = 0;
        for (int n = 0; n < 1000; n++) begin
            if (!wb_stb_o) break;
            sc++;
            @(negedge clk);
        end
`ifdef WB_INITIATOR_TIMEOUT_EN
        chk("to_stb_cycles", sc, 8);
        chk("to_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("to_rsp_err", {31'h0, rsp_err}, 32'h1);
        chk("to_rsp_dat", rsp_dat, 32'h0);
`else
        chk("noto_stb_cycles", sc, 1000);
        chk("noto_rsp_valid", {31'h0, rsp_valid}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
